// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg -- shared definitions for the sequential multiply/divide unit.
//   MD_ITER    : iteration cycles per operation (one result bit per cycle)
//   md_op_e    : operation encoding carried on the op port
//   md_state_e : controller FSM states
// -----------------------------------------------------------------------------
package md_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/md_iter_step.sv
// -----------------------------------------------------------------------------
// md_iter_step -- one combinational iteration of the sequential mul/div.
// Both operations share a 64-bit working register {upper, lower}:
//   multiply : upper = partial product, lower = remaining multiplier bits
//   divide   : upper = partial remainder, lower = dividend / quotient bits
// Ports:
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i    : working register before the step
//   opnd_i   : multiplicand or divisor (magnitude)
//   acc_o    : working register after the step
// Build option: MD_SEQ_DIV_EN includes the divide step; otherwise only the
// multiply step exists and is_div_i is ignored.
// -----------------------------------------------------------------------------
module md_iter_step (
  input  logic        is_div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] acc_o
);

  logic [32:0] sum;

`ifdef MD_SEQ_DIV_EN
  logic [32:0] shifted;
  logic [33:0] diff;
`else
  logic        unused_is_div;
  assign unused_is_div = is_div_i;
`endif

  always_comb begin
    // Add the multiplicand when the current multiplier LSB is set, then shift
    // the 65-bit {carry, upper, lower} right by one.
    sum   = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    acc_o = {sum, acc_i[31:1]};
`ifdef MD_SEQ_DIV_EN
    // Shift the next dividend bit into the remainder and try subtracting the
    // divisor; keep the difference only if it did not go negative.
    shifted = acc_i[63:31];
    diff    = {1'b0, shifted} - {2'b00, opnd_i};
    if (is_div_i) begin
      if (!diff[33]) acc_o = {diff[31:0], acc_i[30:0], 1'b1};
      else           acc_o = {shifted[31:0], acc_i[30:0], 1'b0};
    end
`endif
  end

endmodule

// File: rtl/md_seq_ctrl.sv
// -----------------------------------------------------------------------------
// md_seq_ctrl -- sequential MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// An accepted operation stalls the pipeline for ITER+1 cycles, runs one
// iteration per cycle, writes sign-corrected HI/LO and pulses done.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous, active-low reset
//   start        : valid MULT/MULTU/DIV/DIVU in ID/EX
//   op           : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a/src_b  : forwarded rs / rt operands
//   flush        : abort any operation, no HI/LO update
//   stall        : hold IF/ID/EX
//   busy         : iteration in progress (MFHI/MFLO interlock)
//   done         : one-cycle completion pulse
//   div_by_zero  : pulses with done on a divide by zero
//   hi/lo        : architectural HI/LO
// Build option: MD_SEQ_DIV_EN enables divide; without it divide starts are
// ignored and div_by_zero is tied low.
// -----------------------------------------------------------------------------
module md_seq_ctrl
  import md_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] LAST = 5'(ITER - 1);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        sa_q, sa_d;           // operand A was negative (signed op)
  logic        sb_q, sb_d;           // operand B was negative (signed op)
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        op_ok, accept, is_signed, sa, sb;
  logic [31:0] abs_a, abs_b, res_hi, res_lo;
  logic [63:0] step_acc, prod;

`ifdef MD_SEQ_DIV_EN
  logic dbz_q, dbz_d;
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[1];
`endif

  assign accept    = (state_q == ST_IDLE) && start && !flush && op_ok;
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign sa        = is_signed & src_a[31];
  assign sb        = is_signed & src_b[31];
  assign abs_a     = sa ? -src_a : src_a;
  assign abs_b     = sb ? -src_b : src_b;

  md_iter_step u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  // Sign correction is applied to the final step's output so HI/LO are
  // written on the same edge the last iteration completes.
  always_comb begin
    prod   = (sa_q ^ sb_q) ? -step_acc : step_acc;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
`ifdef MD_SEQ_DIV_EN
    if (is_div_q) begin
      res_lo = (sa_q ^ sb_q) ? -step_acc[31:0]  : step_acc[31:0];
      res_hi = sa_q          ? -step_acc[63:32] : step_acc[63:32];
    end
`endif
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MD_SEQ_DIV_EN
    dbz_d    = 1'b0;
`endif
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d  = ST_RUN;
            cnt_d    = 5'd0;
            acc_d    = {32'd0, abs_a};
            opnd_d   = abs_b;
            is_div_d = op[1];
            sa_d     = sa;
            sb_d     = sb;
`ifdef MD_SEQ_DIV_EN
            if (op[1] && (src_b == 32'd0)) begin
              state_d = ST_DONE;
              hi_d    = src_a;
              lo_d    = 32'hFFFF_FFFF;
              dbz_d   = 1'b1;
            end
`endif
          end
        end
        ST_RUN: begin
          acc_d = step_acc;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: operand and accumulator registers are reset too, so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
`ifdef MD_SEQ_DIV_EN
      dbz_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MD_SEQ_DIV_EN
      dbz_q    <= dbz_d;
`endif
    end
  end

  assign stall = accept || (state_q == ST_RUN);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE) && !flush;
`ifdef MD_SEQ_DIV_EN
  assign div_by_zero = done && dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif
  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_seq_ctrl -- self-checking bench for md_seq_ctrl. Expected HI/LO come
// from plain 64-bit arithmetic on the operands; timing expectations come from
// the cycle budget of the unit (ITER+1 stall cycles, done one cycle later).
// Honours MD_SEQ_DIV_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_md_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall, busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  always #5 clk = ~clk;

  md_seq_ctrl #(.ITER(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result from ordinary 64-bit arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml, output logic mdbz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    mdbz = 1'b0;
    q    = 0;
    r    = 0;
    case (o)
      2'b00:   p = 64'(sa * sb);
      2'b01:   p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          p    = {a, 32'hFFFF_FFFF};
          mdbz = 1'b1;
        end else begin
          if (o == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
          end
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    mh = p[63:32];
    ml = p[31:0];
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 15));
      4:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Issue one operation and follow it to completion (or a cycle budget).
  // hold keeps start asserted through RUN/DONE to show it is ignored there.
  task automatic exec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] mh, ml, got_hi, got_lo;
    logic        mdbz, got_dbz;
    bit          sup, seen;
    int          cyc, stall_n, busy_n, done_at;
    sup = 1'b1;
`ifndef MD_SEQ_DIV_EN
    if (o[1]) sup = 1'b0;
`endif
    model(o, a, b, mh, ml, mdbz);
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    seen = 1'b0; cyc = 0; stall_n = 0; busy_n = 0; done_at = -1;
    got_dbz = 1'b0; got_hi = hi; got_lo = lo;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (done) begin
        seen    = 1'b1;
        done_at = cyc;
        got_dbz = div_by_zero;
        got_hi  = hi;
        got_lo  = lo;
        check("stall_at_done", 64'(stall), 64'd0);
        check("busy_at_done", 64'(busy), 64'd0);
      end
      if (stall) stall_n++;
      if (busy)  busy_n++;
      @(posedge clk); #1;
      if (!hold || seen) start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    if (sup) begin
      check("done_seen", 64'(seen), 64'd1);
      check("latency", 64'(done_at), mdbz ? 64'd1 : 64'd33);
      check("stall_cycles", 64'(stall_n), mdbz ? 64'd1 : 64'd33);
      check("busy_cycles", 64'(busy_n), mdbz ? 64'd0 : 64'd32);
      check("div_by_zero", 64'(got_dbz), 64'(mdbz));
      exp_hi = mh;
      exp_lo = ml;
    end else begin
      check("unsup_done", 64'(seen), 64'd0);
      check("unsup_stall", 64'(stall_n), 64'd0);
      got_hi = hi;
      got_lo = lo;
    end
    check("hi", 64'(got_hi), 64'(exp_hi));
    check("lo", 64'(got_lo), 64'(exp_lo));
  endtask

  // Start an operation and abort it in RUN cycle 10 by flush or reset.
  task automatic abort_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit use_reset);
    int done_n;
    done_n = 0;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy_before", 64'(busy), 64'd1);
    if (use_reset) begin
      reset = 1'b0;
      #1;
      exp_hi = 32'd0;
      exp_lo = 32'd0;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
    end else begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy_after", 64'(busy), 64'd0);
    end
    repeat (40) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort_no_done", 64'(done_n), 64'd0);
    check("abort_hi", 64'(hi), 64'(exp_hi));
    check("abort_lo", 64'(lo), 64'(exp_lo));
  endtask

  // start together with flush in IDLE must not be accepted.
  task automatic flush_start();
    int busy_n, done_n;
    busy_n = 0;
    done_n = 0;
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n++;
    end
    check("fs_busy", 64'(busy_n), 64'd0);
    check("fs_done", 64'(done_n), 64'd0);
    check("fs_hi", 64'(hi), 64'(exp_hi));
    check("fs_lo", 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    exec(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    exec(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b1);
    exec(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    exec(2'b11, 32'd100, 32'd7, 1'b0);
    exec(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    exec(2'b10, 32'd5, 32'd0, 1'b0);
    exec(2'b11, 32'hDEAD_BEEF, 32'd0, 1'b1);
    exec(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);

    exec(2'b01, 32'd6, 32'd7, 1'b0);
    abort_op(2'b00, 32'd3, 32'd4, 1'b0);
    flush_start();
    abort_op(2'b00, 32'd3, 32'd4, 1'b1);

    for (int i = 0; i < 30; i++) begin
      exec(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
